// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: keeps one icache request in flight, predecodes each reply to
// predict the next PC, and buffers {inst, pc, pred_taken, pred_pc} in a circular queue for decode.
module inst_fetch_queue #(
  parameter int unsigned QUEUE_WIDTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter bit          JALR_STALL  = 1'b1
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 clr_in,
  input  logic [31:0]          clr_pc,
  output logic                 ic_req_valid,
  output logic [31:0]          ic_req_pc,
  input  logic                 ic_resp_valid,
  input  logic [31:0]          ic_resp_inst,
  output logic [31:0]          bp_pc,
  input  logic                 bp_taken,
  output logic                 out_valid,
  output logic [31:0]          out_inst,
  output logic [31:0]          out_pc,
  output logic                 out_pred_taken,
  output logic [31:0]          out_pred_pc,
  input  logic                 deq_ready,
  output logic [QUEUE_WIDTH:0] queue_count
);

  localparam int unsigned          QUEUE_DEPTH = 1 << QUEUE_WIDTH;
  localparam logic [QUEUE_WIDTH:0] DEPTH_C     = {1'b1, {QUEUE_WIDTH{1'b0}}};
  localparam logic [6:0]           OP_JAL      = 7'b1101111;
  localparam logic [6:0]           OP_BRANCH   = 7'b1100011;
  localparam logic [6:0]           OP_JALR     = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DROP  = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic                   req_q, req_d;
  logic [31:0]            pc_q, pc_d;
  logic [QUEUE_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [QUEUE_WIDTH:0]   count_q, count_d, count_after_deq;

  logic [31:0] mem_inst    [QUEUE_DEPTH];
  logic [31:0] mem_pc      [QUEUE_DEPTH];
  logic        mem_taken   [QUEUE_DEPTH];
  logic [31:0] mem_pred_pc [QUEUE_DEPTH];

  logic        deq_fire, enq_fire;
  logic [6:0]  opcode;
  logic [31:0] imm_j, imm_b, pc_plus4, pred_pc;
  logic        pred_taken, is_jalr;

  // Handshakes: the decoder takes the head on a cycle where out_valid && deq_ready; the icache
  // returns exactly one ic_resp_valid pulse per request. Neither counts while rdy_in is low or
  // while clr_in flushes the front end.
  assign deq_fire = rdy_in && !clr_in && (count_q != '0) && deq_ready;
  assign enq_fire = rdy_in && !clr_in && (state_q == S_FETCH) && ic_resp_valid;
  assign count_after_deq = count_q - (QUEUE_WIDTH + 1)'(deq_fire);

  // Predecode of the returned instruction against the address it was fetched from.
  assign opcode   = ic_resp_inst[6:0];
  assign imm_j    = {{12{ic_resp_inst[31]}}, ic_resp_inst[19:12], ic_resp_inst[20],
                     ic_resp_inst[30:21], 1'b0};
  assign imm_b    = {{20{ic_resp_inst[31]}}, ic_resp_inst[7], ic_resp_inst[30:25],
                     ic_resp_inst[11:8], 1'b0};
  assign pc_plus4 = pc_q + 32'd4;
  assign is_jalr  = (opcode == OP_JALR);

  always_comb begin
    pred_taken = 1'b0;
    pred_pc    = pc_plus4;
    if (opcode == OP_JAL) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + imm_j;
    end else if ((opcode == OP_BRANCH) && bp_taken) begin
      pred_taken = 1'b1;
      pred_pc    = pc_q + imm_b;
    end
  end

  // State register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      pc_q    <= RESET_PC;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Next-state logic; flush has priority over every other event.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (rdy_in) begin
      if (clr_in) begin
        pc_d = clr_pc;
        if ((state_q == S_FETCH) || (state_q == S_DROP))
          state_d = ic_resp_valid ? S_IDLE : S_DROP;
        else
          state_d = S_IDLE;
      end else begin
        case (state_q)
          S_IDLE:  if (count_after_deq < DEPTH_C) state_d = S_FETCH;
          S_FETCH: if (ic_resp_valid) begin
            pc_d    = pred_pc;
            state_d = (is_jalr && JALR_STALL) ? S_HALT : S_IDLE;
          end
          S_DROP:  if (ic_resp_valid) state_d = S_IDLE;
          default: state_d = state_q;
        endcase
      end
    end
    req_d = (state_d == S_FETCH) || (state_d == S_DROP);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in && clr_in) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (deq_fire) head_d = head_q + QUEUE_WIDTH'(1);
      if (enq_fire) tail_d = tail_q + QUEUE_WIDTH'(1);
      count_d = count_after_deq + (QUEUE_WIDTH + 1)'(enq_fire);
    end
  end

  // A reply only arrives for the single outstanding request, which was issued with a free slot.
  always_ff @(posedge clk_in) begin
    if (enq_fire) begin
      mem_inst[tail_q]    <= ic_resp_inst;
      mem_pc[tail_q]      <= pc_q;
      mem_taken[tail_q]   <= pred_taken;
      mem_pred_pc[tail_q] <= pred_pc;
    end
  end

  // Outputs
  always_comb begin
    ic_req_valid   = req_q;
    ic_req_pc      = pc_q;
    bp_pc          = pc_q;
    queue_count    = count_q;
    out_valid      = (count_q != '0);
    out_inst       = '0;
    out_pc         = '0;
    out_pred_taken = 1'b0;
    out_pred_pc    = '0;
    if (out_valid) begin
      out_inst       = mem_inst[head_q];
      out_pc         = mem_pc[head_q];
      out_pred_taken = mem_taken[head_q];
      out_pred_pc    = mem_pred_pc[head_q];
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: icache/predictor/decoder drivers, a transaction-level model of
// the fetch front end with an expected queue, directed scenarios and a randomized run.
module tb_inst_fetch_queue;

  localparam int          QW    = 4;
  localparam int          DEPTH = 1 << QW;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic [31:0] clr_pc;
  logic        ic_req_valid;
  logic [31:0] ic_req_pc;
  logic        ic_resp_valid;
  logic [31:0] ic_resp_inst;
  logic [31:0] bp_pc;
  logic        bp_taken;
  logic        out_valid;
  logic [31:0] out_inst, out_pc, out_pred_pc;
  logic        out_pred_taken;
  logic        deq_ready;
  logic [QW:0] queue_count;

  inst_fetch_queue #(.QUEUE_WIDTH(QW), .RESET_PC(32'h0), .JALR_STALL(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in), .clr_pc(clr_pc),
    .ic_req_valid(ic_req_valid), .ic_req_pc(ic_req_pc), .ic_resp_valid(ic_resp_valid),
    .ic_resp_inst(ic_resp_inst), .bp_pc(bp_pc), .bp_taken(bp_taken), .out_valid(out_valid),
    .out_inst(out_inst), .out_pc(out_pc), .out_pred_taken(out_pred_taken),
    .out_pred_pc(out_pred_pc), .deq_ready(deq_ready), .queue_count(queue_count)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Model: entries packed {inst[96:65], pc[64:33], taken[32], pred_pc[31:0]}
  logic [96:0] exp_q[$];
  logic [31:0] m_pc;
  bit          m_busy, m_stale, m_halt;

  // Stimulus knobs and icache state
  int          rdy_pct, deq_mode, bp_mode, lat_min, lat_max, clr_pct;
  bit          rand_prog, deq_once, clr_next;
  logic [31:0] clr_next_pc;
  logic [31:0] prog [logic [31:0]];
  bit          ic_busy, ic_done, ic_stale;
  int          ic_wait;
  logic [31:0] ic_addr;
  logic [32:0] deq_log[$];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    int v;
    v = int'(i[30:21]) * 2 + int'(i[20]) * 2048 + int'(i[19:12]) * 4096;
    if (i[31]) v = v - (1 << 20);
    return 32'(v);
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    int v;
    v = int'(i[11:8]) * 2 + int'(i[30:25]) * 32 + int'(i[7]) * 2048;
    if (i[31]) v = v - 4096;
    return 32'(v);
  endfunction

  function automatic logic [31:0] rand_inst();
    int          r;
    logic [31:0] x;
    r = int'($urandom_range(99));
    x = $urandom();
    if (r < 45) return NOP;
    if (r < 60) return {x[31:7], 7'h6F};
    if (r < 80) return {x[31:7], 7'h63};
    if (r < 84) return {x[31:7], 7'h67};
    return {x[31:7], 7'h33};
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    if (rand_prog) return rand_inst();
    if (prog.exists(a)) return prog[a];
    return NOP;
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_pc = 32'h0; m_busy = 0; m_stale = 0; m_halt = 0;
  endfunction

  // One clock of the front end, evaluated from this cycle's inputs.
  function automatic void model_step();
    bit          idle;
    logic [31:0] inst, nxt;
    bit          tk;
    if (!rdy_in) return;
    if (clr_in) begin
      m_stale = (m_busy || m_stale) && !ic_resp_valid;
      m_busy  = 0;
      m_halt  = 0;
      exp_q.delete();
      m_pc = clr_pc;
      return;
    end
    idle = !m_busy && !m_stale && !m_halt;
    if (exp_q.size() != 0 && deq_ready) void'(exp_q.pop_front());
    if (m_busy && ic_resp_valid) begin
      inst = ic_resp_inst;
      nxt  = m_pc + 32'd4;
      tk   = 0;
      if (inst[6:0] == 7'h6F) begin
        tk = 1; nxt = m_pc + imm_j(inst);
      end else if (inst[6:0] == 7'h63 && bp_taken) begin
        tk = 1; nxt = m_pc + imm_b(inst);
      end
      exp_q.push_back({inst, m_pc, tk, nxt});
      if (inst[6:0] == 7'h67) m_halt = 1;
      m_busy = 0;
      m_pc   = nxt;
    end else if (m_stale && ic_resp_valid) begin
      m_stale = 0;
    end else if (idle && exp_q.size() < DEPTH) begin
      m_busy = 1;
    end
  endfunction

  // Compare process body: DUT outputs against the model, sampled at the falling edge.
  task automatic compare();
    chk("req_valid", 32'(ic_req_valid), 32'(m_busy || m_stale));
    chk("req_pc", ic_req_pc, m_pc);
    chk("bp_pc", bp_pc, m_pc);
    chk("count", 32'(queue_count), 32'(exp_q.size()));
    chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      chk("out_inst", out_inst, exp_q[0][96:65]);
      chk("out_pc", out_pc, exp_q[0][64:33]);
      chk("out_taken", 32'(out_pred_taken), 32'(exp_q[0][32]));
      chk("out_pred_pc", out_pred_pc, exp_q[0][31:0]);
    end
  endtask

  // Driver: decoder, predictor, icache and flush inputs for the next rising edge.
  task automatic drive();
    rdy_in = (rdy_pct == 0) ? 1'b1 : (int'($urandom_range(99)) >= rdy_pct);
    clr_in = 1'b0;
    if (clr_next) begin
      clr_in = 1'b1; clr_pc = clr_next_pc; clr_next = 0;
    end else if (clr_pct != 0 && int'($urandom_range(99)) < clr_pct) begin
      clr_in = 1'b1; clr_pc = $urandom() & 32'hFFFF_FFFC;
    end
    if (deq_once) begin
      deq_ready = 1'b1; deq_once = 0;
    end else begin
      deq_ready = (deq_mode == 1) || (deq_mode == 2 && $urandom_range(1) == 1);
    end
    bp_taken = (bp_mode == 1) || (bp_mode == 2 && $urandom_range(1) == 1);
    ic_resp_valid = 1'b0;
    ic_resp_inst  = $urandom();
    if (!ic_req_valid) ic_busy = 0;
    else if (!ic_busy) begin
      ic_busy = 1; ic_done = 0; ic_addr = ic_req_pc;
      ic_wait = int'($urandom_range(32'(lat_max), 32'(lat_min)));
    end
    if (ic_stale) begin
      ic_stale = 0;
      if (!ic_req_valid) begin ic_resp_valid = 1'b1; ic_resp_inst = 32'h0200_006F; end
    end else if (rdy_in && ic_busy && !ic_done) begin
      if (ic_wait == 0) begin
        ic_resp_valid = 1'b1; ic_resp_inst = fetch_word(ic_addr); ic_done = 1;
      end else ic_wait--;
    end else if (!rdy_in && ic_busy && !ic_done && $urandom_range(1) == 1) begin
      ic_resp_valid = 1'b1; ic_resp_inst = 32'h0200_006F;
    end
    if (out_valid && deq_ready && rdy_in && !clr_in) deq_log.push_back({out_pred_taken, out_pc});
  endtask

  task automatic cycle();
    drive();
    model_step();
    @(negedge clk_in);
    compare();
  endtask

  task automatic set_knobs(int rp, int dm, int bm, int lmin, int lmax, int cp, bit rprog);
    rdy_pct = rp; deq_mode = dm; bp_mode = bm; lat_min = lmin; lat_max = lmax;
    clr_pct = cp; rand_prog = rprog; deq_once = 0; clr_next = 0;
    prog.delete(); deq_log.delete();
  endtask

  // Asynchronous reset raised mid-cycle, possibly with a request in flight.
  task automatic do_reset();
    #2;
    rst_in = 1'b1;
    rdy_in = 1'b1; clr_in = 1'b0; clr_pc = '0; ic_resp_valid = 1'b0; ic_resp_inst = '0;
    bp_taken = 1'b0; deq_ready = 1'b0;
    ic_stale = ic_busy; ic_busy = 0; ic_done = 0;
    @(negedge clk_in);
    @(negedge clk_in);
    model_reset();
    compare();
    chk("rst_count", 32'(queue_count), 32'h0);
    chk("rst_req_valid", 32'(ic_req_valid), 32'h0);
    chk("rst_req_pc", ic_req_pc, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_inst", out_inst, 32'h0);
    chk("rst_out_pred_pc", out_pred_pc, 32'h0);
    rst_in = 1'b0;
  endtask

  task automatic wait_count(string name, int target, int bound);
    bit found = 0;
    for (int n = 0; n < bound; n++) begin
      if (int'(queue_count) >= target) begin found = 1; break; end
      cycle();
    end
    chk(name, 32'(found), 32'h1);
  endtask

  task automatic wait_req(string name, int bound);
    bit found = 0;
    for (int n = 0; n < bound; n++) begin
      if (ic_req_valid) begin found = 1; break; end
      cycle();
    end
    chk(name, 32'(found), 32'h1);
  endtask

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    bit found;
    int reqs;
    rst_in = 1'b1;
    ic_busy = 0; ic_done = 0; ic_stale = 0; ic_wait = 0; ic_addr = '0;
    set_knobs(0, 1, 0, 0, 0, 0, 0);
    do_reset();

    // Eight NOPs from 0x0 drain in order
    begin
      found = 0;
      for (int n = 0; n < 200; n++) begin
        if (deq_log.size() >= 8) begin found = 1; break; end
        cycle();
      end
      chk("nop_deq8", 32'(found), 32'h1);
      if (found) for (int i = 0; i < 8; i++) begin
        chk("nop_pc", deq_log[i][31:0], 32'(i * 4));
        chk("nop_taken", 32'(deq_log[i][32]), 32'h0);
      end
    end

    // Saturation at 16 entries, then one dequeue refetches 0x40
    set_knobs(0, 0, 0, 0, 1, 0, 0);
    do_reset();
    wait_count("full_reach", DEPTH, 300);
    repeat (5) cycle();
    chk("full_count", 32'(queue_count), 32'd16);
    chk("full_noreq", 32'(ic_req_valid), 32'h0);
    deq_once = 1;
    wait_req("refetch_req", 10);
    chk("refetch_pc", ic_req_pc, 32'h40);
    chk("refetch_count", 32'(queue_count), 32'd15);

    // JAL at 0x100
    set_knobs(0, 0, 0, 0, 2, 0, 0);
    prog[32'h100] = 32'h0200_006F;
    do_reset();
    clr_next = 1; clr_next_pc = 32'h100;
    cycle();
    wait_count("jal_entry", 1, 40);
    chk("jal_pc", out_pc, 32'h100);
    chk("jal_pred_pc", out_pred_pc, 32'h120);
    chk("jal_taken", 32'(out_pred_taken), 32'h1);
    wait_req("jal_req", 10);
    chk("jal_next_req", ic_req_pc, 32'h120);

    // BEQ +16 at 0x200, predicted taken then not taken
    for (int b = 1; b >= 0; b--) begin
      set_knobs(0, 0, b, 0, 2, 0, 0);
      prog[32'h200] = 32'h0000_0863;
      do_reset();
      clr_next = 1; clr_next_pc = 32'h200;
      cycle();
      wait_count("beq_entry", 1, 40);
      chk("beq_pred_pc", out_pred_pc, (b == 1) ? 32'h210 : 32'h204);
      chk("beq_taken", 32'(out_pred_taken), 32'(b));
      wait_req("beq_req", 10);
      chk("beq_next_req", ic_req_pc, (b == 1) ? 32'h210 : 32'h204);
    end

    // JALR at 0x300 halts fetch until a flush
    set_knobs(0, 1, 0, 0, 2, 0, 0);
    prog[32'h300] = 32'h0000_8067;
    do_reset();
    clr_next = 1; clr_next_pc = 32'h300;
    cycle();
    wait_count("jalr_entry", 1, 40);
    chk("jalr_pred_pc", out_pred_pc, 32'h304);
    chk("jalr_taken", 32'(out_pred_taken), 32'h0);
    reqs = 0;
    for (int n = 0; n < 20; n++) begin
      cycle();
      if (ic_req_valid) reqs++;
    end
    chk("halt_noreq", 32'(reqs), 32'h0);
    clr_next = 1; clr_next_pc = 32'h400;
    cycle();
    wait_req("halt_exit_req", 10);
    chk("halt_exit_pc", ic_req_pc, 32'h400);

    // Flush with 0x40 outstanding and five entries queued
    set_knobs(0, 0, 0, 2, 2, 0, 0);
    do_reset();
    clr_next = 1; clr_next_pc = 32'h2C;
    cycle();
    found = 0;
    for (int n = 0; n < 100; n++) begin
      if (queue_count == 5 && ic_req_valid && ic_req_pc == 32'h40) begin found = 1; break; end
      cycle();
    end
    chk("flush_setup", 32'(found), 32'h1);
    clr_next = 1; clr_next_pc = 32'h800;
    cycle();
    chk("flush_count", 32'(queue_count), 32'h0);
    chk("flush_drop_pc", ic_req_pc, 32'h800);
    wait_count("flush_entry", 1, 40);
    chk("flush_first_pc", out_pc, 32'h800);

    // Randomized traffic with stalls, flushes and a mid-run reset
    set_knobs(20, 2, 2, 0, 3, 3, 1);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      cycle();
      if (n == 1500) do_reset();
    end
    set_knobs(50, 2, 2, 0, 4, 2, 1);
    for (int n = 0; n < 1500; n++) cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
